// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to the IM
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add o_checksum (mod-2^32 sum of written words)
module imem_loader #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [ADDR_BITS:0] i_len_words,
    input  logic               i_byte_valid,
    input  logic [7:0]         i_byte_data,
    output logic               o_byte_ready,
    output logic               o_im_we,
    output logic [31:0]        o_im_addr,
    output logic [31:0]        o_im_wdata,
    output logic               o_busy,
    output logic               o_done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0]        o_checksum,
`endif
    output logic               o_len_err
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
    localparam logic [ADDR_BITS:0] L_CAP = {1'b1, {ADDR_BITS{1'b0}}};
    state_t             r_state;
    logic [ADDR_BITS:0] r_len;
    logic [ADDR_BITS:0] r_word_cnt;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_buf;
    logic               r_byte_ready;
    logic               r_im_we;
    logic [31:0]        r_im_addr;
    logic [31:0]        r_im_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_len_err;
    logic               w_start_ok;
    logic               w_xfer;
    logic [ADDR_BITS:0] w_len;
    logic [ADDR_BITS:0] w_word_nxt;
    logic [31:0]        w_addr;
    logic [31:0]        w_buf_nxt;
    assign w_start_ok   = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_xfer       = r_byte_ready && i_byte_valid;
    assign w_len        = (i_len_words > L_CAP) ? L_CAP : i_len_words;
    assign w_word_nxt   = r_word_cnt + (ADDR_BITS + 1)'(1);
    assign w_addr       = BASE_ADDR + 32'({r_word_cnt, 2'b00});
    assign w_buf_nxt    = {r_buf[23:0], i_byte_data};
    assign o_byte_ready = r_byte_ready;
    assign o_im_we      = r_im_we;
    assign o_im_addr    = r_im_addr;
    assign o_im_wdata   = r_im_wdata;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_len_err    = r_len_err;
    // Load sequencer: accepts start, packs four bytes per word, issues one write cycle per word
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_byte_cnt   <= '0;
            r_buf        <= '0;
            r_byte_ready <= 1'b0;
            r_im_we      <= 1'b0;
            r_im_addr    <= BASE_ADDR;
            r_im_wdata   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_len      <= w_len;
                        r_len_err  <= i_len_words > L_CAP;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        if (w_len != '0) begin
                            r_state      <= S_RECV;
                            r_busy       <= 1'b1;
                            r_byte_ready <= 1'b1;
                            r_done       <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_xfer) begin
                        r_buf      <= w_buf_nxt;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_im_we      <= 1'b1;
                            r_im_wdata   <= w_buf_nxt;
                            r_im_addr    <= w_addr;
                        end
                    end
                end
                S_WRITE: begin
                    r_im_we    <= 1'b0;
                    r_word_cnt <= w_word_nxt;
                    r_byte_cnt <= '0;
                    if (w_word_nxt == r_len) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_RECV;
                        r_byte_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;
    assign o_checksum = r_checksum;
    // Running sum of written words, restarted by every accepted start
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_checksum <= '0;
        else if (w_start_ok) r_checksum <= '0;
        else if (r_state == S_WRITE) r_checksum <= r_checksum + r_im_wdata;
    end
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked against a word-level write model
module tb_imem_loader;
    localparam int          AB   = 10;
    localparam int          CAP  = 1 << AB;
    localparam logic [31:0] BASE = 32'h0000_3000;
    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_start;
    logic [AB:0]   i_len_words;
    logic          i_byte_valid;
    logic [7:0]    i_byte_data;
    logic          o_byte_ready;
    logic          o_im_we;
    logic [31:0]   o_im_addr;
    logic [31:0]   o_im_wdata;
    logic          o_busy;
    logic          o_done;
    logic          o_len_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]   o_checksum;
`endif
    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    wr_t         exp_q[$];
    logic [7:0]  prog[0:4*CAP-1];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          n_load = 0;
    int          t_start = 0;
    int          last_we_cyc = 0;
    bit          b2b_mode = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] exp_sum = '0;
    imem_loader #(.ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_len_words(i_len_words),
        .i_byte_valid(i_byte_valid),
        .i_byte_data(i_byte_data),
        .o_byte_ready(o_byte_ready),
        .o_im_we(o_im_we),
        .o_im_addr(o_im_addr),
        .o_im_wdata(o_im_wdata),
        .o_busy(o_busy),
        .o_done(o_done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .o_checksum(o_checksum),
`endif
        .o_len_err(o_len_err)
    );
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Every IM write must be the next word of the model's expected sequence
    always @(negedge i_clk) begin
        wr_t e;
        if (!i_reset && o_im_we) begin
            chk("extra_we", 32'(wr_cnt >= n_load), 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("we_addr", o_im_addr, e.addr);
                chk("we_data", o_im_wdata, e.data);
            end
            chk("we_ready_low", o_byte_ready, 0);
            chk("we_busy", o_busy, 1);
            if (b2b_mode) chk("we_cycle", cyc - t_start, 5 * (wr_cnt + 1));
            wr_cnt++;
            last_we_cyc = cyc;
            last_addr = o_im_addr;
            last_data = o_im_wdata;
        end
    end
    task automatic chk_reset_vals();
        chk("rst_ready", o_byte_ready, 0);
        chk("rst_we", o_im_we, 0);
        chk("rst_addr", o_im_addr, BASE);
        chk("rst_wdata", o_im_wdata, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_len_err", o_len_err, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("rst_checksum", o_checksum, 0);
`endif
    endtask
    task automatic fill(input int nb);
        for (int k = 0; k < nb; k++) prog[k] = 8'($urandom);
    endtask
    task automatic run_load(input int len, input bit b2b, input int pct, input bit inject);
        int n;
        int idx;
        int budget;
        int done_cyc;
        bit seen;
        bit v;
        logic [31:0] w;
        n = (len > CAP) ? CAP : len;
        idx = 0;
        seen = 1'b0;
        done_cyc = 0;
        exp_sum = '0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            w = {prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3]};
            exp_q.push_back('{BASE + 32'(4 * k), w});
            exp_sum += w;
        end
        @(negedge i_clk);
        wr_cnt = 0;
        n_load = n;
        b2b_mode = b2b;
        i_start = 1'b1;
        i_len_words = (AB + 1)'(len);
        t_start = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        budget = 20 * n + 20;
        for (int c = 0; c < budget && !seen; c++) begin
            if (o_done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else begin
                chk("busy_during_load", o_busy, 1);
                v = b2b || ($urandom_range(99) < pct);
                i_start = inject && c == 7;
                if (inject && c == 7) i_len_words = (AB + 1)'($urandom);
                i_byte_valid = v;
                i_byte_data = (o_byte_ready && idx < 4 * n) ? prog[idx] : 8'($urandom);
                if (v && o_byte_ready) idx++;
                @(negedge i_clk);
            end
        end
        i_byte_valid = 1'b0;
        i_start = 1'b0;
        chk("done_seen", 32'(seen), 1);
        chk("done_cycle", done_cyc, (n != 0) ? last_we_cyc + 1 : t_start + 1);
        chk("len_err", o_len_err, 32'(len > CAP));
        chk("write_count", wr_cnt, n);
        chk("writes_left", exp_q.size(), 0);
        chk("busy_after_done", o_busy, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("checksum", o_checksum, exp_sum);
`endif
        repeat (2) @(negedge i_clk);
        chk("done_held", o_done, 1);
        chk("len_err_held", o_len_err, 32'(len > CAP));
    endtask
    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_len_words = '0;
        i_byte_valid = 1'b0;
        i_byte_data = '0;
        #3;
        chk_reset_vals();
        @(negedge i_clk);
        i_reset = 1'b0;
        // abandon a load after two bytes with an asynchronous reset
        @(negedge i_clk);
        i_start = 1'b1;
        i_len_words = (AB + 1)'(2);
        @(negedge i_clk);
        i_start = 1'b0;
        i_byte_valid = 1'b1;
        i_byte_data = 8'hAA;
        @(negedge i_clk);
        i_byte_data = 8'hBB;
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        #2 i_reset = 1'b1;
        #1 chk_reset_vals();
        @(negedge i_clk);
        i_reset = 1'b0;
        prog[0] = 8'h24; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h01;
        run_load(1, 1'b1, 100, 1'b0);
        chk("t1_addr", last_addr, 32'h0000_3000);
        chk("t1_data", last_data, 32'h2400_0001);
        fill(12);
        run_load(3, 1'b1, 100, 1'b0);
        chk("t2_last_addr", last_addr, 32'h0000_3008);
        run_load(2, 1'b0, 50, 1'b0);
        chk("t3_last_addr", last_addr, 32'h0000_3004);
        run_load(0, 1'b1, 100, 1'b0);
        fill(4 * CAP);
        run_load(CAP + 1, 1'b1, 100, 1'b0);
        chk("t4_last_addr", last_addr, 32'h0000_3FFC);
        chk("t4_count", wr_cnt, 1024);
        fill(12);
        run_load(3, 1'b0, 70, 1'b1);
        prog[0] = 8'hFF; prog[1] = 8'hFF; prog[2] = 8'hFF; prog[3] = 8'hFF;
        prog[4] = 8'h00; prog[5] = 8'h00; prog[6] = 8'h00; prog[7] = 8'h02;
        run_load(2, 1'b1, 100, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("t6_checksum", o_checksum, 32'h0000_0001);
`endif
        fill(4 * CAP);
        run_load(CAP, 1'b0, 90, 1'b0);
        chk("full_last_addr", last_addr, 32'h0000_3FFC);
        repeat (6) begin
            fill(80);
            run_load($urandom_range(1, 20), 1'b0, $urandom_range(30, 100), 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
